// File: rtl/mips_core_pkg.sv
// Shared widths and the packed whole-file image type for the MIPS integer register file.
// Register i of a reg_array_t lives at bits [i*DATA_WIDTH +: DATA_WIDTH].
package mips_core_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int NUM_REGS   = 32;
    localparam int ADDR_WIDTH = 5;

    typedef logic [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_array_t;

endpackage

// File: rtl/mod_port_recovery_done_tracker.sv
// Restore-complete flag: set by a snapshot restore, cleared by the controller's ack.
// A restore request outranks ack, so done stays up while restore is still asserted.
module recovery_done_tracker (
    input  logic clk,
    input  logic rst_n,
    input  logic restore,
    input  logic ack,
    output logic done
);

    logic done_reg;
    logic done_next;

    always_comb begin
        done_next = done_reg;
        if (restore) begin
            done_next = 1'b1;
        end else if (ack) begin
            done_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_reg <= 1'b0;
        end else begin
            done_reg <= done_next;
        end
    end

    assign done = done_reg;

endmodule

// File: rtl/mod_port.sv
// MIPS architectural register file: two combinational read ports, one write-back port,
// and a whole-file snapshot restore that overrides write-back for misprediction recovery.
module mod_port
    import mips_core_pkg::*;
#(
    parameter int DATA_WIDTH = mips_core_pkg::DATA_WIDTH,
    parameter int NUM_REGS   = mips_core_pkg::NUM_REGS,
    parameter int ADDR_WIDTH = mips_core_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  uses_rs,
    input  logic [ADDR_WIDTH-1:0] rs_addr,
    input  logic                  uses_rt,
    input  logic [ADDR_WIDTH-1:0] rt_addr,
    input  logic                  wb_uses_rw,
    input  logic [ADDR_WIDTH-1:0] wb_rw_addr,
    input  logic [DATA_WIDTH-1:0] wb_rw_data,
    output logic [DATA_WIDTH-1:0] rs_data,
    output logic [DATA_WIDTH-1:0] rt_data,
    input  logic                  recover_snapshot,
    input  logic                  recovery_done_ack,
    input  reg_array_t            regs_snapshot,
    output reg_array_t            regs_out,
    output logic                  done
);

    // Register 0 is hardwired to zero, so its snapshot word is intentionally ignored.
    logic snap_r0_unused;
    assign snap_r0_unused = ^regs_snapshot[0];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign regs_out[gi] = '0;
            end else begin : g_live
                logic                  wr_hit;
                logic [DATA_WIDTH-1:0] word_reg;

                assign wr_hit = wb_uses_rw && (wb_rw_addr == ADDR_WIDTH'(gi));

                // Restore wins over a same-edge write-back to the same register.
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        word_reg <= '0;
                    end else if (recover_snapshot) begin
                        word_reg <= regs_snapshot[gi];
                    end else if (wr_hit) begin
                        word_reg <= wb_rw_data;
                    end
                end

                assign regs_out[gi] = word_reg;
            end
        end
    endgenerate

    // Reads come straight from the flops: no write-to-read bypass.
    assign rs_data = uses_rs ? regs_out[rs_addr] : '0;
    assign rt_data = uses_rt ? regs_out[rt_addr] : '0;

    recovery_done_tracker u_done (
        .clk     (clk),
        .rst_n   (rst_n),
        .restore (recover_snapshot),
        .ack     (recovery_done_ack),
        .done    (done)
    );

endmodule

// File: tb/tb_mod_port.sv
// Scoreboard bench for mod_port: stimulus queues expected values after each edge,
// a negedge monitor drains the queue and compares against the live outputs.
module tb_mod_port;
    import mips_core_pkg::*;

    localparam int K_RS   = 0;
    localparam int K_RT   = 1;
    localparam int K_WORD = 2;
    localparam int K_DONE = 3;

    typedef struct {
        string       name;
        int          kind;
        int          idx;
        logic [31:0] val;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        uses_rs;
    logic [4:0]  rs_addr;
    logic        uses_rt;
    logic [4:0]  rt_addr;
    logic        wb_uses_rw;
    logic [4:0]  wb_rw_addr;
    logic [31:0] wb_rw_data;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        recover_snapshot;
    logic        recovery_done_ack;
    reg_array_t  regs_snapshot;
    reg_array_t  regs_out;
    logic        done;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    mod_port dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .uses_rs           (uses_rs),
        .rs_addr           (rs_addr),
        .uses_rt           (uses_rt),
        .rt_addr           (rt_addr),
        .wb_uses_rw        (wb_uses_rw),
        .wb_rw_addr        (wb_rw_addr),
        .wb_rw_data        (wb_rw_data),
        .rs_data           (rs_data),
        .rt_data           (rt_data),
        .recover_snapshot  (recover_snapshot),
        .recovery_done_ack (recovery_done_ack),
        .regs_snapshot     (regs_snapshot),
        .regs_out          (regs_out),
        .done              (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_val(input string name, input int kind, input int idx,
                              input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every queued expectation against the settled outputs.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.kind)
                K_RS:    act = rs_data;
                K_RT:    act = rt_data;
                K_WORD:  act = regs_out[e.idx];
                default: act = {31'd0, done};
            endcase
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s actual=%h required=%h", e.name, act, e.val);
            end else begin
                $display("ok   %s value=%h", e.name, act);
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        uses_rs = 1'b0; rs_addr = '0;
        uses_rt = 1'b0; rt_addr = '0;
        wb_uses_rw = 1'b0; wb_rw_addr = '0; wb_rw_data = '0;
        recover_snapshot = 1'b0; recovery_done_ack = 1'b0;
        regs_snapshot = '0;

        // Reset state
        step();
        step();
        rst_n = 1'b1;
        uses_rs = 1'b1; rs_addr = 5'd5;
        expect_val("reset_done", K_DONE, 0, 32'd0);
        expect_val("reset_r5", K_WORD, 5, 32'd0);
        expect_val("reset_rs_r5", K_RS, 0, 32'd0);

        // Write r5 then read it back on both read paths
        uses_rs = 1'b0;
        wb_uses_rw = 1'b1; wb_rw_addr = 5'd5; wb_rw_data = 32'hDEADBEEF;
        step();
        wb_uses_rw = 1'b0;
        uses_rs = 1'b1; rs_addr = 5'd5;
        expect_val("rs_r5", K_RS, 0, 32'hDEADBEEF);
        step();
        uses_rs = 1'b0;
        expect_val("rs_r5_unused", K_RS, 0, 32'd0);

        // Writes to r0 are dropped
        wb_uses_rw = 1'b1; wb_rw_addr = 5'd0; wb_rw_data = 32'h12345678;
        step();
        wb_uses_rw = 1'b0;
        uses_rt = 1'b1; rt_addr = 5'd0;
        expect_val("rt_r0", K_RT, 0, 32'd0);
        expect_val("word_r0", K_WORD, 0, 32'd0);

        // Same-cycle write and read: old value now, new value after the edge
        wb_uses_rw = 1'b1; wb_rw_addr = 5'd7; wb_rw_data = 32'h11111111;
        step();
        wb_rw_data = 32'hA5A5A5A5;
        uses_rs = 1'b1; rs_addr = 5'd7;
        expect_val("rs_r7_old", K_RS, 0, 32'h11111111);
        step();
        wb_uses_rw = 1'b0;
        expect_val("rs_r7_new", K_RS, 0, 32'hA5A5A5A5);

        // Restore colliding with a write-back to r3
        for (int i = 0; i < NUM_REGS; i++) regs_snapshot[i] = 32'h100 + 32'(i);
        recover_snapshot = 1'b1;
        wb_uses_rw = 1'b1; wb_rw_addr = 5'd3; wb_rw_data = 32'hFFFFFFFF;
        expect_val("done_before_restore", K_DONE, 0, 32'd0);
        step();
        recover_snapshot = 1'b0;
        wb_uses_rw = 1'b0;
        rs_addr = 5'd3;
        expect_val("rs_r3_restored", K_RS, 0, 32'h103);
        expect_val("restore_r0", K_WORD, 0, 32'd0);
        for (int i = 1; i < NUM_REGS; i++)
            expect_val($sformatf("restore_r%0d", i), K_WORD, i, 32'h100 + 32'(i));
        expect_val("done_after_restore", K_DONE, 0, 32'd1);

        // done holds without ack
        for (int i = 0; i < 5; i++) begin
            step();
            expect_val($sformatf("done_hold_%0d", i), K_DONE, 0, 32'd1);
        end

        // One-cycle ack clears done
        recovery_done_ack = 1'b1;
        step();
        recovery_done_ack = 1'b0;
        expect_val("done_acked", K_DONE, 0, 32'd0);

        // Ack while done is low changes nothing
        recovery_done_ack = 1'b1;
        step();
        expect_val("ack_idle", K_DONE, 0, 32'd0);

        // Ack held during a two-cycle restore: done stays high, reload each cycle
        for (int i = 0; i < NUM_REGS; i++) regs_snapshot[i] = 32'h200 + 32'(i);
        recover_snapshot = 1'b1;
        step();
        expect_val("done_ack_restore_1", K_DONE, 0, 32'd1);
        expect_val("restore2_r4", K_WORD, 4, 32'h204);
        regs_snapshot[4] = 32'h0000_0444;
        step();
        expect_val("done_ack_restore_2", K_DONE, 0, 32'd1);
        expect_val("reload_r4", K_WORD, 4, 32'h444);
        recover_snapshot = 1'b0;
        step();
        recovery_done_ack = 1'b0;
        expect_val("done_ack_after", K_DONE, 0, 32'd0);

        // Reset with done high and registers loaded, restore pending at the same edge
        recover_snapshot = 1'b1;
        step();
        recover_snapshot = 1'b0;
        expect_val("done_pre_reset", K_DONE, 0, 32'd1);
        rst_n = 1'b0;
        recover_snapshot = 1'b1;
        step();
        rst_n = 1'b1;
        recover_snapshot = 1'b0;
        expect_val("reset_done_clear", K_DONE, 0, 32'd0);
        for (int i = 0; i < NUM_REGS; i++)
            expect_val($sformatf("reset2_r%0d", i), K_WORD, i, 32'd0);
        expect_val("reset2_rs_r3", K_RS, 0, 32'd0);

        n = 0;
        while (sb_q.size() > 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
